// File: rtl/pet_video_pkg.sv
// rtl/pet_video_pkg.sv - PET video generator timing constants and geometry helpers
//
// Purpose: default PET 40- and 80-column raster constants, the glyph-line
// field width function and active-area helpers shared by the video blocks.
package pet_video_pkg;

    // 40-column PET raster
    localparam int PET40_COLS     = 40;
    localparam int PET40_ROWS     = 25;
    localparam int PET40_CHAR_H   = 8;
    localparam int PET40_H_TOTAL  = 448;
    localparam int PET40_V_TOTAL  = 262;
    localparam int PET40_HS_START = 358;
    localparam int PET40_HS_END   = 391;
    localparam int PET40_VS_START = 225;
    localparam int PET40_VS_END   = 234;
    localparam int PET40_ADDR_W   = 11;

    // 80-column PET raster (taller glyphs need a longer frame)
    localparam int PET80_COLS     = 80;
    localparam int PET80_ROWS     = 25;
    localparam int PET80_CHAR_H   = 10;
    localparam int PET80_H_TOTAL  = 896;
    localparam int PET80_V_TOTAL  = 312;
    localparam int PET80_HS_START = 716;
    localparam int PET80_HS_END   = 782;
    localparam int PET80_VS_START = 270;
    localparam int PET80_VS_END   = 279;
    localparam int PET80_ADDR_W   = 11;

    // Bits needed to count glyph lines 0..char_h-1 (at least one bit)
    function automatic int glyph_lw(input int char_h);
        int w;
        w = 1;
        while ((1 << w) < char_h) w++;
        return w;
    endfunction

    // Pixels per active line
    function automatic int active_px(input int cols);
        return cols * 8;
    endfunction

    // Active lines per frame
    function automatic int active_lines(input int rows, input int char_h);
        return rows * char_h;
    endfunction

endpackage

// File: rtl/pet_video_timing.sv
// rtl/pet_video_timing.sv - H/V counters, syncs, video_on and vertical-blank pulse
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ce_7mp, ce_7mn    counter-phase / sample-phase pixel enables
//   hc                horizontal pixel counter
//   line_end          hc is on the last pixel of the line
//   frame_end         vc is on the last line of the frame
//   HSync, VSync      active-high syncs, updated on ce_7mn
//   video_on          vc inside the active rows
//   vblank_irq        one-clk pulse when vc steps into vertical blank
module pet_video_timing
    import pet_video_pkg::*;
#(
    parameter int ROWS     = PET40_ROWS,
    parameter int CHAR_H   = PET40_CHAR_H,
    parameter int H_TOTAL  = PET40_H_TOTAL,
    parameter int V_TOTAL  = PET40_V_TOTAL,
    parameter int HS_START = PET40_HS_START,
    parameter int HS_END   = PET40_HS_END,
    parameter int VS_START = PET40_VS_START,
    parameter int VS_END   = PET40_VS_END,
    parameter int HC_W     = $clog2(H_TOTAL),
    parameter int VC_W     = $clog2(V_TOTAL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce_7mp,
    input  logic            ce_7mn,
    output logic [HC_W-1:0] hc,
    output logic            line_end,
    output logic            frame_end,
    output logic            HSync,
    output logic            VSync,
    output logic            video_on,
    output logic            vblank_irq
);
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] VC_LAST  = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] VC_ACT   = VC_W'(active_lines(ROWS, CHAR_H));
    localparam logic [VC_W-1:0] VC_ACT_L = VC_W'(active_lines(ROWS, CHAR_H) - 1);
    localparam logic [HC_W-1:0] HS_ON    = HC_W'(HS_START);
    localparam logic [HC_W-1:0] HS_OFF   = HC_W'(HS_END);
    localparam logic [VC_W-1:0] VS_ON    = VC_W'(VS_START);
    localparam logic [VC_W-1:0] VS_OFF   = VC_W'(VS_END);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            irq_q, irq_d;

    assign line_end  = (hc_q == HC_LAST);
    assign frame_end = (vc_q == VC_LAST);

    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        irq_d   = 1'b0;
        if (ce_7mp) begin
            if (line_end) begin
                hc_d  = '0;
                vc_d  = frame_end ? '0 : vc_q + 1'b1;
                // vc is about to step from the last active line into blank
                irq_d = (vc_q == VC_ACT_L);
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
        if (ce_7mn) begin
            // A zero-length sync window keeps the sync permanently low
            if (HS_START != HS_END) begin
                if (hc_q == HS_ON)       hsync_d = 1'b1;
                else if (hc_q == HS_OFF) hsync_d = 1'b0;
            end
            if (VS_START != VS_END) begin
                if (vc_q == VS_ON)       vsync_d = 1'b1;
                else if (vc_q == VS_OFF) vsync_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            irq_q   <= irq_d;
        end
    end

    assign hc         = hc_q;
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign video_on   = (vc_q < VC_ACT);
    assign vblank_irq = irq_q;

endmodule

// File: rtl/pet_video_gen.sv
// rtl/pet_video_gen.sv - PET text/graphics video generator top
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ce_7mp, ce_7mn        counter-phase / sample-phase pixel enables
//   start_addr            screen start address, latched at frame wrap
//   video_gfx             graphics character set select
//   video_blank           forces pix low
//   video_addr/video_data video RAM address and screen code (bit7 inverse)
//   charaddr/chardata     char ROM address {gfx, code[6:0], glyph_line} and row
//   pix, de               pixel and display enable
//   HSync, VSync          active-high syncs
//   video_on, vblank_irq  active rows flag, vertical-blank pulse
module pet_video_gen
    import pet_video_pkg::*;
#(
    parameter int COLS     = PET40_COLS,
    parameter int ROWS     = PET40_ROWS,
    parameter int CHAR_H   = PET40_CHAR_H,
    parameter int LW       = glyph_lw(CHAR_H),
    parameter int H_TOTAL  = PET40_H_TOTAL,
    parameter int V_TOTAL  = PET40_V_TOTAL,
    parameter int HS_START = PET40_HS_START,
    parameter int HS_END   = PET40_HS_END,
    parameter int VS_START = PET40_VS_START,
    parameter int VS_END   = PET40_VS_END,
    parameter int ADDR_W   = PET40_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_7mp,
    input  logic              ce_7mn,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              video_gfx,
    input  logic              video_blank,
    output logic [ADDR_W-1:0] video_addr,
    input  logic [7:0]        video_data,
    output logic [8+LW-1:0]   charaddr,
    input  logic [7:0]        chardata,
    output logic              pix,
    output logic              HSync,
    output logic              VSync,
    output logic              de,
    output logic              video_on,
    output logic              vblank_irq
);
    localparam int HC_W = $clog2(H_TOTAL);
    localparam int VC_W = $clog2(V_TOTAL);
    localparam logic [HC_W-1:0]   HC_ACT   = HC_W'(active_px(COLS));
    localparam logic [LW-1:0]     GL_LAST  = LW'(CHAR_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

    if (active_px(COLS) > HS_START) begin : g_bad_cols
        $error("active width exceeds HS_START");
    end
    if (active_lines(ROWS, CHAR_H) > VS_START) begin : g_bad_rows
        $error("active height exceeds VS_START");
    end
    if (HS_END >= H_TOTAL || VS_END >= V_TOTAL) begin : g_bad_sync
        $error("sync end outside the frame");
    end
    if (glyph_lw(CHAR_H) > LW) begin : g_bad_lw
        $error("LW too narrow for CHAR_H");
    end

    logic [HC_W-1:0] hc;
    logic            line_end;
    logic            frame_end;
    logic            active;

    pet_video_timing #(
        .ROWS     (ROWS),
        .CHAR_H   (CHAR_H),
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .HS_START (HS_START),
        .HS_END   (HS_END),
        .VS_START (VS_START),
        .VS_END   (VS_END),
        .HC_W     (HC_W),
        .VC_W     (VC_W)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .ce_7mp     (ce_7mp),
        .ce_7mn     (ce_7mn),
        .hc         (hc),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .HSync      (HSync),
        .VSync      (VSync),
        .video_on   (video_on),
        .vblank_irq (vblank_irq)
    );

    logic [LW-1:0]     glyph_line_q, glyph_line_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [7:0]        shift_q, shift_d;
    logic              inv_q, inv_d;
    logic              de_q, de_d;

    assign active = video_on && (hc < HC_ACT);

    // Row base is accumulated per character row, so no multiplier is needed
    always_comb begin
        glyph_line_d = glyph_line_q;
        row_base_d   = row_base_q;
        start_d      = start_q;
        if (ce_7mp && line_end) begin
            if (frame_end) begin
                glyph_line_d = '0;
                row_base_d   = '0;
                start_d      = start_addr;
            end else if (video_on) begin
                if (glyph_line_q == GL_LAST) begin
                    glyph_line_d = '0;
                    row_base_d   = row_base_q + ROW_STEP;
                end else begin
                    glyph_line_d = glyph_line_q + 1'b1;
                end
            end
        end
    end

    // Cell load happens on the sample phase of each 8-pixel boundary, when
    // the RAM/ROM reads for the new hc have settled
    always_comb begin
        shift_d = shift_q;
        inv_d   = inv_q;
        de_d    = de_q;
        if (ce_7mn) begin
            if (hc[2:0] == 3'd0) begin
                if (active) begin
                    inv_d   = video_data[7];
                    shift_d = chardata;
                    de_d    = 1'b1;
                end else begin
                    inv_d   = 1'b0;
                    shift_d = '0;
                    de_d    = 1'b0;
                end
            end else begin
                shift_d = {shift_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glyph_line_q <= '0;
            row_base_q   <= '0;
            start_q      <= '0;
            shift_q      <= '0;
            inv_q        <= 1'b0;
            de_q         <= 1'b0;
        end else begin
            glyph_line_q <= glyph_line_d;
            row_base_q   <= row_base_d;
            start_q      <= start_d;
            shift_q      <= shift_d;
            inv_q        <= inv_d;
            de_q         <= de_d;
        end
    end

    // Address arithmetic wraps modulo 2^ADDR_W by truncation
    assign video_addr = start_q + row_base_q + ADDR_W'(hc[HC_W-1:3]);
    assign charaddr   = {video_gfx, video_data[6:0], glyph_line_q};
    assign pix        = (shift_q[7] ^ inv_q) & ~video_blank & de_q;
    assign de         = de_q;

endmodule

// File: tb/tb_pet_video_gen.sv
// tb/tb_pet_video_gen.sv - self-checking bench for pet_video_gen
module tb_pet_video_gen;
    localparam int COLS = 4, ROWS = 3, CHAR_H = 3, LW = 2;
    localparam int H_TOTAL = 48, V_TOTAL = 14;
    localparam int HS_START = 36, HS_END = 42, VS_START = 10, VS_END = 12;
    localparam int ADDR_W = 5;
    localparam int FRAME = H_TOTAL * V_TOTAL;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ce_7mp = 1'b0, ce_7mn = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              video_gfx = 1'b0, video_blank = 1'b0;
    logic [ADDR_W-1:0] video_addr;
    logic [7:0]        video_data;
    logic [8+LW-1:0]   charaddr;
    logic [7:0]        chardata;
    logic              pix, HSync, VSync, de, video_on, vblank_irq;

    logic [7:0] vram [32];
    logic [7:0] crom [1024];
    assign video_data = vram[video_addr];
    assign chardata   = crom[charaddr];

    always #5 clk = ~clk;

    pet_video_gen #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .LW(LW),
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .HS_START(HS_START), .HS_END(HS_END), .VS_START(VS_START), .VS_END(VS_END),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .ce_7mp(ce_7mp), .ce_7mn(ce_7mn),
        .start_addr(start_addr), .video_gfx(video_gfx), .video_blank(video_blank),
        .video_addr(video_addr), .video_data(video_data),
        .charaddr(charaddr), .chardata(chardata),
        .pix(pix), .HSync(HSync), .VSync(VSync), .de(de),
        .video_on(video_on), .vblank_irq(vblank_irq)
    );

    int errors = 0;
    int checks = 0;
    int n = 0;                       // ce_7mp count since reset
    int frame_start = 0;             // start address in effect this frame
    bit rand_blank = 1'b0;

    typedef struct {
        logic [7:0] code;
        logic [7:0] glyph;
        logic       gfx;
        logic       blank;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    function automatic int hc_of(input int k); return k % H_TOTAL; endfunction
    function automatic int vc_of(input int k); return (k / H_TOTAL) % V_TOTAL; endfunction
    function automatic bit act_at(input int k);
        return hc_of(k) < COLS * 8 && vc_of(k) < ROWS * CHAR_H;
    endfunction
    function automatic int exp_addr(input int k);
        return (frame_start + (vc_of(k) / CHAR_H) * COLS + hc_of(k) / 8) % (1 << ADDR_W);
    endfunction

    // Counter phase: position advances, address/flags checked against the model
    task automatic phase_p();
        int s;
        logic [7:0] code;
        logic [1:0] gl;
        logic [9:0] ca;
        s = int'(start_addr);
        ce_7mp = 1'b1;
        @(posedge clk); #1 ce_7mp = 1'b0;
        n++;
        if (n % FRAME == 0) frame_start = s;
        #1;
        check("video_on", video_on, vc_of(n) < ROWS * CHAR_H);
        check("irq_p", vblank_irq, (n % FRAME) == ROWS * CHAR_H * H_TOTAL);
        if (act_at(n)) begin
            check("video_addr", video_addr, exp_addr(n));
            code = vram[exp_addr(n)];
            gl   = 2'(vc_of(n) % CHAR_H);
            ca   = {video_gfx, code[6:0], gl};
            check("charaddr", charaddr, ca);
        end
    endtask

    // Sample phase: pixel, display enable and syncs checked
    task automatic phase_n();
        logic [7:0] code, glyph;
        logic [1:0] gl;
        logic [9:0] ci;
        logic       ep;
        ce_7mn = 1'b1;
        @(posedge clk); #1 ce_7mn = 1'b0;
        if (rand_blank) video_blank = ($urandom_range(0, 3) == 0);
        #1;
        ep = 1'b0;
        if (act_at(n)) begin
            code  = vram[exp_addr(n)];
            gl    = 2'(vc_of(n) % CHAR_H);
            ci    = {video_gfx, code[6:0], gl};
            glyph = crom[ci];
            ep    = (glyph[7 - hc_of(n) % 8] ^ code[7]) & ~video_blank;
        end
        check("pix", pix, ep);
        check("de", de, act_at(n));
        check("hsync", HSync, hc_of(n) >= HS_START && hc_of(n) < HS_END);
        check("vsync", VSync, vc_of(n) >= VS_START && vc_of(n) < VS_END);
        check("irq_n", vblank_irq, 0);
    endtask

    task automatic do_reset();
        ce_7mp = 1'b0;
        ce_7mn = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        frame_start = 0;
        phase_n();
    endtask

    task automatic run_to(input int target, input bit rand_start);
        while (n < target) begin
            if (rand_start && $urandom_range(0, 199) == 0)
                start_addr = ADDR_W'($urandom_range(0, 31));
            phase_p();
            phase_n();
        end
    endtask

    initial begin
        logic [7:0] got;
        logic [9:0] idx;
        logic [9:0] ca_exp;
        int target;

        tbl[0] = '{8'h81, 8'hA5, 1'b0, 1'b0, 8'h5A};
        tbl[1] = '{8'h81, 8'hA5, 1'b0, 1'b1, 8'h00};
        tbl[2] = '{8'h01, 8'hA5, 1'b1, 1'b0, 8'hA5};
        tbl[3] = '{8'h80, 8'h00, 1'b0, 1'b0, 8'hFF};
        tbl[4] = '{8'h7F, 8'h3C, 1'b1, 1'b0, 8'h3C};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00};
        tbl[6] = '{8'h00, 8'h81, 1'b0, 1'b0, 8'h81};

        for (int i = 0; i < 32; i++)   vram[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) crom[i] = 8'($urandom);

        // Reset state
        #3;
        check("rst_pix", pix, 0);
        check("rst_de", de, 0);
        check("rst_hsync", HSync, 0);
        check("rst_vsync", VSync, 0);
        check("rst_irq", vblank_irq, 0);
        check("rst_addr", video_addr, 0);

        // Serialiser vectors: first cell of the first line after reset
        start_addr = '0;
        rand_blank = 1'b0;
        for (int v = 0; v < 7; v++) begin
            vram[0]     = tbl[v].code;
            idx         = {tbl[v].gfx, tbl[v].code[6:0], 2'd0};
            crom[idx]   = tbl[v].glyph;
            video_gfx   = tbl[v].gfx;
            video_blank = tbl[v].blank;
            do_reset();
            got[7] = pix;
            for (int b = 6; b >= 0; b--) begin
                phase_p();
                phase_n();
                got[b] = pix;
            end
            check("vec_pix", got, tbl[v].exp);
        end

        // Directed addressing and start-address latching
        vram[6]    = 8'hC5;
        video_gfx  = 1'b1;
        start_addr = '0;
        rand_blank = 1'b1;
        do_reset();
        run_to(3 * H_TOTAL + 16, 1'b0);
        check("addr_r1c2", video_addr, 6);
        ca_exp = {1'b1, 7'h45, 2'd0};
        check("charaddr_r1c2", charaddr, ca_exp);
        start_addr = 5'd30;
        run_to(6 * H_TOTAL + 8, 1'b0);
        check("addr_midframe", video_addr, 9);
        run_to(FRAME + 3 * H_TOTAL + 24, 1'b0);
        check("addr_wrap", video_addr, 5);
        start_addr = 5'd7;
        run_to(FRAME + 6 * H_TOTAL, 1'b0);
        check("addr_hold", video_addr, 6);
        run_to(2 * FRAME + 8, 1'b0);
        check("addr_newframe", video_addr, 8);

        // Randomised frames against the model
        video_gfx = 1'b0;
        do_reset();
        run_to(3 * FRAME + 100, 1'b1);

        // Reset mid-line while both syncs are high
        target = (n / FRAME + 1) * FRAME + VS_START * H_TOTAL + HS_START + 2;
        run_to(target, 1'b1);
        check("pre_hsync", HSync, 1);
        check("pre_vsync", VSync, 1);
        start_addr = 5'd17;
        #1 reset = 1'b1;
        #1;
        check("mid_rst_hsync", HSync, 0);
        check("mid_rst_vsync", VSync, 0);
        check("mid_rst_addr", video_addr, 0);
        check("mid_rst_pix", pix, 0);
        check("mid_rst_de", de, 0);
        do_reset();
        run_to(4, 1'b0);
        check("post_rst_addr", video_addr, 0);
        run_to(FRAME + 2 * H_TOTAL + 8, 1'b0);
        check("post_rst_start", video_addr, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pet_video_gen.md
Name: pet_video_gen

Overview:
- Parametrised PET text/graphics video generator; successor to the fixed 40x25 raster block.
- Generates H/V timing, fetches screen codes from video RAM and glyph rows from char ROM, and serialises 8-pixel cells to a 1-bit pixel stream.
- Adds generic column/row/glyph-height geometry, a hardware-scroll start address latched per frame, a display-enable output and a vertical-blank interrupt pulse.
- Sits between the PET bus video RAM / char ROM and the scan-doubler/OSD path.

Parameters:
- COLS, 40, characters per row (40 or 80).
- ROWS, 25, character rows per frame.
- CHAR_H, 8, scanlines per glyph, 1..16.
- LW, 3, glyph line field width = clog2(CHAR_H).
- H_TOTAL, 448, pixel clocks per line.
- V_TOTAL, 262, lines per frame.
- HS_START, 358, HSync rise (hc value).
- HS_END, 391, HSync fall (hc value).
- VS_START, 225, VSync rise (vc value).
- VS_END, 234, VSync fall (vc value).
- ADDR_W, 11, video RAM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_7mp  in  1  pixel enable, counter phase
- ce_7mn  in  1  pixel enable, sample/shift phase (half pixel after ce_7mp)
- start_addr  in  ADDR_W  screen start address (hardware scroll)
- video_gfx  in  1  selects graphics char set (charaddr MSB)
- video_blank  in  1  forces pix low
- video_addr  out  ADDR_W  video RAM address
- video_data  in  8  screen code; bit7 = inverse
- charaddr  out  8+LW  {video_gfx, video_data[6:0], glyph_line}
- chardata  in  8  glyph row, MSB leftmost
- pix  out  1  pixel
- HSync  out  1  active-high horizontal sync
- VSync  out  1  active-high vertical sync
- de  out  1  active-area display enable, aligned with pix
- video_on  out  1  high while vc < ROWS*CHAR_H
- vblank_irq  out  1  one-clk pulse at start of vertical blank

Behaviour:
- Reset (async): all of the following are 0 — hc, vc, col, glyph_line, row_base, start_q, shift register, inv, de, HSync, VSync, vblank_irq, pix.
- Counters advance on ce_7mp only.
  - hc increments; at hc==H_TOTAL-1, hc←0 and vc increments.
  - At vc==V_TOTAL-1 with hc wrapping, vc←0.
- Active area: hc < COLS*8 and vc < ROWS*CHAR_H. col = hc[..:3].
- Row addressing uses no multiplier.
  - On each line wrap inside the active area, glyph_line increments.
  - When glyph_line==CHAR_H-1 it wraps to 0 and row_base += COLS.
  - On frame wrap: glyph_line←0, row_base←0, start_q←start_addr.
  - start_addr changes mid-frame have no effect until the next frame.
- video_addr = (start_q + row_base + col) mod 2^ADDR_W; wrap-around is legal and required.
- Fetch window: RAM and ROM are combinational-read. video_data and chardata are valid at the ce_7mn following the ce_7mp that set hc.
- Serialiser, on ce_7mn:
  - If hc[2:0]==0 and active: load {inv,shift}←{video_data[7],chardata}.
  - If hc[2:0]==0 and not active: load zeros.
  - Otherwise shift left, filling with 0.
  - Pixel latency from cell start is half a pixel.
- pix = (shift[7] ^ inv) & ~video_blank & de. de is registered alongside the load and spans exactly COLS*8 pixels per active line.
- Syncs, updated on ce_7mn:
  - HSync←1 at hc==HS_START, HSync←0 at hc==HS_END.
  - VSync←1 at vc==VS_START, VSync←0 at vc==VS_END.
  - If a start value equals its end value, the sync stays 0.
- vblank_irq: high for exactly one clk on the ce_7mp where vc steps to ROWS*CHAR_H. It is not re-asserted until the next frame.
- Simultaneous events: ce_7mp and ce_7mn never coincide; behaviour if they do is undefined. A reset between fetches aborts the line and restarts at hc=vc=0.
- Elaboration checks: COLS*8 ≤ HS_START, ROWS*CHAR_H ≤ VS_START, HS_END < H_TOTAL, VS_END < V_TOTAL, CHAR_H ≤ 2^LW.

Decomposition:
- Package pet_video_pkg holds:
  - the default PET 40-column and 80-column timing constants;
  - the glyph-line width function;
  - active-area helper constants.
- One sub-module, pet_video_timing, holds the hc/vc counters, syncs, video_on and vblank_irq.
- Address generation and the serialiser live in the top module.

Test Plan:
- Defaults, start_addr=0, reset released → HSync rises at hc=358 and falls at 391; VSync spans vc=225..233; 448*262 ce_7mp per frame.
- Row 1, glyph line 0, col 5 → video_addr=45; charaddr={gfx,code[6:0],3'd0}.
- start_addr=0x7F0 latched, row 1 col 20 → video_addr=(0x7F0+40+20) mod 2048=0x02C.
- video_data=0x81, chardata=0xA5, video_blank=0 → pix sequence 0,1,0,1,1,0,1,0 (inverted); video_blank=1 → all 0.
- COLS=80, CHAR_H=10, ROWS=25 → row_base steps by 80 every 10 lines; vblank_irq is a single pulse when vc becomes 250.
- Assert reset mid-line at hc=100 → all outputs 0 immediately; counting resumes from hc=0, vc=0; start_addr changed mid-frame is used only after the next frame wrap.
